fft_data_input: RTL and testbench

Staging buffer feeding the FFT core's input AXI-Stream. The processor fills a local RAM of interleaved RE/IM 32-bit words through a synchronous write port, then pulses start. The block issues one config beat (forward/inverse) on the FFT config channel and streams POINT_SIZE {IM, RE} beats with tlast on the final beat. It is the upstream counterpart of fft_data_output.

---
 rtl/fft_data_input_if.sv | 21 ++
 rtl/fft_data_input.sv | 95 +++++++++
 tb/tb_fft_data_input.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_data_input_if.sv
// AXI-Stream style config and data channels between fft_data_input and the FFT core.
// The master drives valid/data/last and the slave drives ready.
interface fft_data_input_if;
    logic        cfg_tvalid;
    logic        cfg_tready;
    logic [7:0]  cfg_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [63:0] m_tdata;

    modport master (
        output cfg_tvalid, cfg_tdata, m_tvalid, m_tlast, m_tdata,
        input  cfg_tready, m_tready
    );

    modport slave (
        input  cfg_tvalid, cfg_tdata, m_tvalid, m_tlast, m_tdata,
        output cfg_tready, m_tready
    );
endinterface

// File: rtl/fft_data_input.sv
// Staging RAM for the FFT input: filled word by word while idle, then streamed
// as one config beat followed by POINT_SIZE {IM, RE} data beats.
module fft_data_input #(
    parameter int NFFT               = 3,
    parameter int POINT_SIZE         = 2**NFFT,
    parameter int N_ELEMENTS         = POINT_SIZE*2,
    parameter int ELEMENTS_ADDR_SIZE = $clog2(N_ELEMENTS)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          wEn,
    input  logic [ELEMENTS_ADDR_SIZE-1:0] wAddr,
    input  logic [31:0]                   wData,
    input  logic                          start,
    input  logic                          inverse,
    fft_data_input_if.master              axis,
    output logic                          busy,
    output logic                          sent
);

    typedef enum logic [1:0] {IDLE, CONFIG, STREAM, DONE} state_t;

    localparam logic [ELEMENTS_ADDR_SIZE-1:0] LAST_IDX = ELEMENTS_ADDR_SIZE'(POINT_SIZE-1);

    state_t                        state_q, state_d;
    logic [ELEMENTS_ADDR_SIZE-1:0] idx_q, idx_d;
    logic                          fwd_inv_q, fwd_inv_d;
    logic [31:0]                   ram [N_ELEMENTS];
    logic [ELEMENTS_ADDR_SIZE-1:0] re_addr;
    logic [ELEMENTS_ADDR_SIZE-1:0] im_addr;

    // Writes are only accepted while idle so a frame cannot change under the consumer.
    always_ff @(posedge clk) begin
        if (wEn && state_q == IDLE) begin
            ram[wAddr] <= wData;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            fwd_inv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            fwd_inv_q <= fwd_inv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        fwd_inv_d = fwd_inv_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    fwd_inv_d = ~inverse;
                    idx_d     = '0;
                    state_d   = CONFIG;
                end
            end
            CONFIG: begin
                if (axis.cfg_tready) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // The index parks on the last point rather than wrapping past it.
                if (axis.m_tready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + ELEMENTS_ADDR_SIZE'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    assign re_addr = idx_q << 1;
    assign im_addr = re_addr | ELEMENTS_ADDR_SIZE'(1);

    assign axis.cfg_tvalid = (state_q == CONFIG);
    assign axis.cfg_tdata  = {7'b0, fwd_inv_q};
    assign axis.m_tvalid   = (state_q == STREAM);
    assign axis.m_tlast    = (state_q == STREAM) && (idx_q == LAST_IDX);
    assign axis.m_tdata    = (state_q == STREAM) ? {ram[im_addr], ram[re_addr]} : 64'h0;
    assign busy            = (state_q != IDLE);
    assign sent            = (state_q == DONE);

endmodule

// File: tb/tb_fft_data_input.sv
// Directed bench for fft_data_input: each scenario task drives the block and
// compares outputs against a bench-side copy of the RAM contents.
module tb_fft_data_input;

    localparam int NFFT       = 3;
    localparam int POINT_SIZE = 8;
    localparam int N_ELEMENTS = 16;
    localparam int AW         = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          wEn;
    logic [AW-1:0] wAddr;
    logic [31:0]   wData;
    logic          start;
    logic          inverse;
    logic          busy;
    logic          sent;

    fft_data_input_if axis_if ();

    fft_data_input #(.NFFT(NFFT)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .wEn     (wEn),
        .wAddr   (wAddr),
        .wData   (wData),
        .start   (start),
        .inverse (inverse),
        .axis    (axis_if),
        .busy    (busy),
        .sent    (sent)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model [N_ELEMENTS];
    logic [63:0] cap_data [POINT_SIZE];
    logic        cap_last [POINT_SIZE];
    int          nbeats;
    bit          sent_seen;

    function automatic logic [63:0] exp_beat(input int b);
        return {model[2*b+1], model[2*b]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_ram(input logic [AW-1:0] addr, input logic [31:0] data);
        wEn   = 1'b1;
        wAddr = addr;
        wData = data;
        step();
        wEn   = 1'b0;
    endtask

    task automatic start_frame(input logic inv);
        inverse = inv;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    // Collects beats until the sent pulse, then steps once more into IDLE.
    task automatic drain_frame(input int budget);
        nbeats    = 0;
        sent_seen = 1'b0;
        for (int i = 0; i < POINT_SIZE; i++) begin
            cap_data[i] = 'x;
            cap_last[i] = 1'bx;
        end
        for (int c = 0; c < budget; c++) begin
            if (sent) begin
                sent_seen = 1'b1;
                step();
                break;
            end
            if (axis_if.m_tvalid && axis_if.m_tready) begin
                if (nbeats < POINT_SIZE) begin
                    cap_data[nbeats] = axis_if.m_tdata;
                    cap_last[nbeats] = axis_if.m_tlast;
                end
                nbeats++;
            end
            step();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step();
        step();
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        total++; if (sent !== 1'b0) begin bad++; $display("[TB] FAIL reset_sent got %b want 0", sent); end
        total++; if (axis_if.cfg_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_cfg_tvalid got %b want 0", axis_if.cfg_tvalid); end
        total++; if (axis_if.m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_tvalid got %b want 0", axis_if.m_tvalid); end
        total++; if (axis_if.m_tlast !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_tlast got %b want 0", axis_if.m_tlast); end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_fill();
        for (int k = 0; k < N_ELEMENTS; k++) begin
            write_ram(AW'(k), 32'h1000 + 32'(k));
            model[k] = 32'h1000 + 32'(k);
        end
    endtask

    task automatic test_basic_frame();
        axis_if.cfg_tready = 1'b1;
        axis_if.m_tready   = 1'b1;
        start_frame(1'b0);
        total++; if (axis_if.cfg_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL basic_cfg_tvalid got %b want 1", axis_if.cfg_tvalid); end
        total++; if (axis_if.cfg_tdata !== 8'h01) begin bad++; $display("[TB] FAIL basic_cfg_tdata got %h want 01", axis_if.cfg_tdata); end
        total++; if (axis_if.m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL basic_m_tvalid_in_cfg got %b want 0", axis_if.m_tvalid); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy got %b want 1", busy); end
        step();
        total++; if (axis_if.cfg_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL basic_cfg_tvalid_drop got %b want 0", axis_if.cfg_tvalid); end
        for (int b = 0; b < POINT_SIZE; b++) begin
            total++; if (axis_if.m_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL basic_m_tvalid beat %0d got %b want 1", b, axis_if.m_tvalid); end
            total++; if (axis_if.m_tdata !== exp_beat(b)) begin bad++; $display("[TB] FAIL basic_m_tdata beat %0d got %h want %h", b, axis_if.m_tdata, exp_beat(b)); end
            total++; if (axis_if.m_tlast !== (b == POINT_SIZE-1)) begin bad++; $display("[TB] FAIL basic_m_tlast beat %0d got %b", b, axis_if.m_tlast); end
            step();
        end
        total++; if (sent !== 1'b1) begin bad++; $display("[TB] FAIL basic_sent got %b want 1", sent); end
        total++; if (axis_if.m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL basic_m_tvalid_after got %b want 0", axis_if.m_tvalid); end
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL basic_busy_done got %b want 1", busy); end
        step();
        total++; if (sent !== 1'b0) begin bad++; $display("[TB] FAIL basic_sent_pulse got %b want 0", sent); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL basic_busy_idle got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [15:0] pat;
        int          beats;
        bit          seen;
        pat   = 16'b1011_0010_0110_1001;
        beats = 0;
        seen  = 1'b0;
        axis_if.m_tready = 1'b0;
        start_frame(1'b0);
        for (int c = 0; c < 200; c++) begin
            if (sent) begin
                seen = 1'b1;
                step();
                break;
            end
            if (axis_if.m_tvalid) begin
                if (beats < POINT_SIZE) begin
                    total++; if (axis_if.m_tdata !== exp_beat(beats)) begin bad++; $display("[TB] FAIL bp_m_tdata beat %0d got %h want %h", beats, axis_if.m_tdata, exp_beat(beats)); end
                    total++; if (axis_if.m_tlast !== (beats == POINT_SIZE-1)) begin bad++; $display("[TB] FAIL bp_m_tlast beat %0d got %b", beats, axis_if.m_tlast); end
                end else begin
                    total++; bad++; $display("[TB] FAIL bp_extra_beat got beat %0d want at most %0d", beats, POINT_SIZE-1);
                end
            end
            axis_if.m_tready = pat[c % 16];
            if (axis_if.m_tvalid && axis_if.m_tready) beats++;
            step();
        end
        axis_if.m_tready = 1'b1;
        total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL bp_sent got %b want 1", seen); end
        total++; if (beats !== POINT_SIZE) begin bad++; $display("[TB] FAIL bp_handshakes got %0d want %0d", beats, POINT_SIZE); end
    endtask

    task automatic test_inverse();
        bit seen;
        seen = 1'b0;
        start_frame(1'b1);
        for (int c = 0; c < 40; c++) begin
            if (sent) begin
                seen = 1'b1;
                step();
                break;
            end
            total++; if (axis_if.cfg_tdata !== 8'h00) begin bad++; $display("[TB] FAIL inv_cfg_tdata cycle %0d got %h want 00", c, axis_if.cfg_tdata); end
            inverse = ~inverse;
            step();
        end
        inverse = 1'b0;
        total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL inv_sent got %b want 1", seen); end
    endtask

    task automatic test_cfg_stall();
        axis_if.cfg_tready = 1'b0;
        start_frame(1'b0);
        for (int c = 0; c < 20; c++) begin
            total++; if (axis_if.cfg_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL stall_cfg_tvalid cycle %0d got %b want 1", c, axis_if.cfg_tvalid); end
            total++; if (axis_if.m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL stall_m_tvalid cycle %0d got %b want 0", c, axis_if.m_tvalid); end
            step();
        end
        axis_if.cfg_tready = 1'b1;
        step();
        total++; if (axis_if.m_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL stall_first_beat_valid got %b want 1", axis_if.m_tvalid); end
        total++; if (axis_if.m_tdata !== exp_beat(0)) begin bad++; $display("[TB] FAIL stall_first_beat_data got %h want %h", axis_if.m_tdata, exp_beat(0)); end
        drain_frame(40);
        total++; if (nbeats !== POINT_SIZE) begin bad++; $display("[TB] FAIL stall_beats got %0d want %0d", nbeats, POINT_SIZE); end
        total++; if (sent_seen !== 1'b1) begin bad++; $display("[TB] FAIL stall_sent got %b want 1", sent_seen); end
    endtask

    task automatic test_write_during_stream();
        axis_if.m_tready = 1'b0;
        start_frame(1'b0);
        step();
        write_ram(AW'(0), 32'hDEADBEEF);
        total++; if (axis_if.m_tdata !== exp_beat(0)) begin bad++; $display("[TB] FAIL wr_stream_beat0 got %h want %h", axis_if.m_tdata, exp_beat(0)); end
        axis_if.m_tready = 1'b1;
        drain_frame(40);
        total++; if (nbeats !== POINT_SIZE) begin bad++; $display("[TB] FAIL wr_stream_beats got %0d want %0d", nbeats, POINT_SIZE); end
        for (int b = 0; b < POINT_SIZE; b++) begin
            total++; if (cap_data[b] !== exp_beat(b)) begin bad++; $display("[TB] FAIL wr_stream_data beat %0d got %h want %h", b, cap_data[b], exp_beat(b)); end
        end
        start_frame(1'b0);
        drain_frame(40);
        total++; if (cap_data[0] !== exp_beat(0)) begin bad++; $display("[TB] FAIL wr_second_frame got %h want %h", cap_data[0], exp_beat(0)); end
        write_ram(AW'(0), 32'hCAFE0000);
        model[0] = 32'hCAFE0000;
        start_frame(1'b0);
        drain_frame(40);
        total++; if (cap_data[0] !== 64'h00001001_CAFE0000) begin bad++; $display("[TB] FAIL wr_idle_frame got %h want 00001001cafe0000", cap_data[0]); end
        total++; if (cap_data[1] !== exp_beat(1)) begin bad++; $display("[TB] FAIL wr_idle_frame_b1 got %h want %h", cap_data[1], exp_beat(1)); end
    endtask

    task automatic test_reset_mid_frame();
        axis_if.m_tready = 1'b1;
        start_frame(1'b0);
        step();
        step();
        step();
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        total++; if (axis_if.cfg_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_cfg_tvalid got %b want 0", axis_if.cfg_tvalid); end
        total++; if (axis_if.m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rst_m_tvalid got %b want 0", axis_if.m_tvalid); end
        total++; if (axis_if.m_tlast !== 1'b0) begin bad++; $display("[TB] FAIL rst_m_tlast got %b want 0", axis_if.m_tlast); end
        total++; if (axis_if.m_tdata !== 64'h0) begin bad++; $display("[TB] FAIL rst_m_tdata got %h want 0", axis_if.m_tdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
        for (int c = 0; c < 3; c++) begin
            total++; if (sent !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_sent cycle %0d got %b want 0", c, sent); end
            step();
        end
        start_frame(1'b0);
        drain_frame(40);
        total++; if (nbeats !== POINT_SIZE) begin bad++; $display("[TB] FAIL rst_refill_beats got %0d want %0d", nbeats, POINT_SIZE); end
        for (int b = 0; b < POINT_SIZE; b++) begin
            total++; if (cap_data[b] !== exp_beat(b)) begin bad++; $display("[TB] FAIL rst_refill_data beat %0d got %h want %h", b, cap_data[b], exp_beat(b)); end
            total++; if (cap_last[b] !== (b == POINT_SIZE-1)) begin bad++; $display("[TB] FAIL rst_refill_last beat %0d got %b", b, cap_last[b]); end
        end
    endtask

    task automatic test_back_to_back();
        axis_if.m_tready = 1'b1;
        inverse = 1'b0;
        start   = 1'b1;
        step();
        drain_frame(40);
        total++; if (nbeats !== POINT_SIZE) begin bad++; $display("[TB] FAIL b2b_first_beats got %0d want %0d", nbeats, POINT_SIZE); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle_gap got %b want 0", busy); end
        step();
        total++; if (axis_if.cfg_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_retrigger got %b want 1", axis_if.cfg_tvalid); end
        start = 1'b0;
        drain_frame(40);
        total++; if (nbeats !== POINT_SIZE) begin bad++; $display("[TB] FAIL b2b_second_beats got %0d want %0d", nbeats, POINT_SIZE); end
        total++; if (sent_seen !== 1'b1) begin bad++; $display("[TB] FAIL b2b_second_sent got %b want 1", sent_seen); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn             = 1'b0;
        wEn                = 1'b0;
        wAddr              = '0;
        wData              = '0;
        start              = 1'b0;
        inverse            = 1'b0;
        axis_if.cfg_tready = 1'b1;
        axis_if.m_tready   = 1'b1;
        test_reset();
        test_fill();
        test_basic_frame();
        test_backpressure();
        test_inverse();
        test_cfg_stall();
        test_write_during_stream();
        test_reset_mid_frame();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
